// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register-bank engine.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  // Bit counter must hold the longest field length.
  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// Load/shift-out register for SPI read data; miso is the register MSB.
module spi_shift_tx #(
  parameter int DATA_W = 8
) (
  input  logic              SCLK_sig,
  input  logic              nrst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_val,
  output logic              miso
);

  logic [DATA_W-1:0] tx_shift;

  always_ff @(posedge SCLK_sig or negedge nrst) begin
    if (!nrst)      tx_shift <= '0;
    else if (clear) tx_shift <= '0;
    else if (load)  tx_shift <= load_val;
    else if (shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
  end

  assign miso = tx_shift[DATA_W-1];

endmodule

// File: rtl/spi_regbank_engine.sv
// SPI frame decoder and register bank in the SCLK domain.
// Define SPI_BURST_EN for auto-incrementing multi-word frames.
//
// state  | meaning
// S_CMD  | after reset: next edge samples the cmd bit
// S_ADDR | shifting in the address field
// S_DATA | shifting data in (write) or out (read)
// S_IDLE | frame complete, edges ignored until next frame start
module spi_regbank_engine
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       nrst,
  input  logic                       SCLK_sig,
  input  logic                       cs_active,
  input  logic                       cs_epoch,
  input  logic                       mosi,
  output logic                       miso,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       commit_toggle,
  output logic [ADDR_W-1:0]          commit_addr,
  output logic                       addr_err
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              epoch_seen;
  logic              cmd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              frame_start, last_addr, last_data;
  logic [ADDR_W-1:0] addr_full, rd_addr;
  logic [DATA_W-1:0] data_full, rd_word;
  logic              cnt_clr, cnt_inc, tx_load, tx_shift_en, tx_clear;
  logic              commit_en, err_set;
`ifdef SPI_BURST_EN
  logic              addr_step;
  logic [ADDR_W-1:0] addr_inc;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  assign frame_start = cs_active && (cs_epoch != epoch_seen);
  assign last_addr   = (state == S_ADDR) && (bit_cnt == CNT_W'(ADDR_W-1));
  assign last_data   = (state == S_DATA) && (bit_cnt == CNT_W'(DATA_W-1));
  assign addr_full   = {addr_r[ADDR_W-2:0], mosi};
  assign data_full   = {rx_sh, mosi};

`ifdef SPI_BURST_EN
  assign addr_inc = (addr_r == ADDR_W'(NUM_REGS-1)) ? '0 : addr_r + ADDR_W'(1);
  assign rd_addr  = (state == S_ADDR) ? addr_full : addr_inc;
`else
  assign rd_addr  = addr_full;
`endif

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (rd_addr == ADDR_W'(r)) rd_word = regs[r];
  end

  always_ff @(posedge SCLK_sig or negedge nrst) begin
    if (!nrst) state <= S_CMD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_clear    = 1'b0;
    commit_en   = 1'b0;
    err_set     = 1'b0;
`ifdef SPI_BURST_EN
    addr_step   = 1'b0;
`endif
    if (frame_start) begin
      state_nxt = S_ADDR;
      cnt_clr   = 1'b1;
      tx_clear  = 1'b1;
    end else if (cs_active) begin
      case (state)
        S_CMD: begin
          state_nxt = S_ADDR;
          cnt_clr   = 1'b1;
        end
        S_ADDR: begin
          if (last_addr) begin
            state_nxt = S_DATA;
            cnt_clr   = 1'b1;
            err_set   = !in_range(addr_full);
            tx_load   = (cmd_r == CMD_READ);
          end else begin
            cnt_inc = 1'b1;
          end
        end
        S_DATA: begin
          if (last_data) begin
            cnt_clr   = 1'b1;
            commit_en = (cmd_r == CMD_WRITE) && in_range(addr_r);
`ifdef SPI_BURST_EN
            addr_step = 1'b1;
            err_set   = !in_range(addr_inc);
            tx_load   = (cmd_r == CMD_READ);
`else
            state_nxt = S_IDLE;
            tx_clear  = 1'b1;
`endif
          end else begin
            cnt_inc     = 1'b1;
            tx_shift_en = (cmd_r == CMD_READ);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCLK_sig or negedge nrst) begin
    if (!nrst) begin
      bit_cnt       <= '0;
      epoch_seen    <= 1'b0;
      cmd_r         <= 1'b0;
      addr_r        <= '0;
      rx_sh         <= '0;
      commit_toggle <= 1'b0;
      commit_addr   <= '0;
      addr_err      <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);

      if (frame_start) begin
        epoch_seen <= cs_epoch;
        cmd_r      <= mosi;
        addr_r     <= '0;
        rx_sh      <= '0;
      end else if (cs_active) begin
        if (state == S_CMD)  cmd_r  <= mosi;
        if (state == S_ADDR) addr_r <= addr_full;
        if (state == S_DATA) rx_sh  <= last_data ? '0 : data_full[DATA_W-2:0];
        if (commit_en) begin
          for (int r = 0; r < NUM_REGS; r++)
            if (addr_r == ADDR_W'(r)) regs[r] <= data_full;
          commit_toggle <= ~commit_toggle;
          commit_addr   <= addr_r;
        end
        if (err_set) addr_err <= 1'b1;
`ifdef SPI_BURST_EN
        if (addr_step) addr_r <= addr_inc;
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  spi_shift_tx #(.DATA_W(DATA_W)) u_tx (
    .SCLK_sig (SCLK_sig),
    .nrst     (nrst),
    .load     (tx_load),
    .shift    (tx_shift_en),
    .clear    (tx_clear),
    .load_val (rd_word),
    .miso     (miso)
  );

endmodule
